// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - byte-serial load/store unit for the MEM stage
`ifndef MEM_LSU_OPS
`define MEM_LSU_OPS
`define AluOpBus   7:0
`define ALU_ADD_OP 8'b00100000
`define ALU_LB_OP  8'b11100000
`define ALU_LH_OP  8'b11100001
`define ALU_LW_OP  8'b11100011
`define ALU_LBU_OP 8'b11100100
`define ALU_LHU_OP 8'b11100101
`define ALU_SB_OP  8'b11101000
`define ALU_SH_OP  8'b11101001
`define ALU_SW_OP  8'b11101011
`endif

module mem_lsu (
  input  logic              dclk,
  input  logic              rst,
  input  logic [`AluOpBus]  aluop_i,
  input  logic              wreg_i,
  input  logic [4:0]        waddr_i,
  input  logic [31:0]       alurslt_i,
  input  logic [31:0]       storedata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              wreg_o,
  output logic [4:0]        waddr_o,
  output logic [31:0]       wdata_o,
  output logic              stall_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          k_q;
  logic [31:0]         base_q;
  logic [31:0]         sdata_q;
  logic [31:0]         buf_q;
  logic [`AluOpBus]    op_q;
  logic [4:0]          waddr_q;
  logic                wreg_q;

  function automatic logic is_mem(input logic [`AluOpBus] op);
    case (op)
      `ALU_LB_OP, `ALU_LH_OP, `ALU_LW_OP, `ALU_LBU_OP, `ALU_LHU_OP,
      `ALU_SB_OP, `ALU_SH_OP, `ALU_SW_OP: is_mem = 1'b1;
      default:                            is_mem = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [`AluOpBus] op);
    case (op)
      `ALU_SB_OP, `ALU_SH_OP, `ALU_SW_OP: is_store = 1'b1;
      default:                            is_store = 1'b0;
    endcase
  endfunction

  // Index of the final byte of the access (byte count minus one).
  function automatic logic [1:0] last_k(input logic [`AluOpBus] op);
    case (op)
      `ALU_LH_OP, `ALU_LHU_OP, `ALU_SH_OP: last_k = 2'd1;
      `ALU_LW_OP, `ALU_SW_OP:              last_k = 2'd3;
      default:                             last_k = 2'd0;
    endcase
  endfunction

  // Memory port is a pure function of registered state, so no input reaches it.
  assign mem_req_o   = (state_q == ACCESS);
  assign mem_we_o    = mem_req_o && is_store(op_q);
  assign mem_addr_o  = mem_req_o ? (base_q + {30'd0, k_q}) : 32'd0;
  assign mem_wdata_o = mem_req_o ? sdata_q[{k_q, 3'b000} +: 8] : 8'd0;

  // FSM state register; reset abandons any access in flight.
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Latch the operation on entry and assemble load bytes as they are acked.
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      k_q     <= 2'd0;
      base_q  <= 32'd0;
      sdata_q <= 32'd0;
      buf_q   <= 32'd0;
      op_q    <= '0;
      waddr_q <= 5'd0;
      wreg_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_mem(aluop_i)) begin
            k_q     <= 2'd0;
            base_q  <= alurslt_i;
            sdata_q <= storedata_i;
            buf_q   <= 32'd0;
            op_q    <= aluop_i;
            waddr_q <= waddr_i;
            wreg_q  <= wreg_i;
          end
        end
        ACCESS: begin
          if (mem_ack_i) begin
            if (!is_store(op_q)) buf_q[{k_q, 3'b000} +: 8] <= mem_rdata_i;
            if (k_q != last_k(op_q)) k_q <= k_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and write-back/stall outputs; non-memory ops pass straight through.
  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    wreg_o  = wreg_i;
    waddr_o = waddr_i;
    wdata_o = alurslt_i;
    case (state_q)
      IDLE: begin
        if (is_mem(aluop_i)) begin
          stall_o = 1'b1;
          wreg_o  = 1'b0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        stall_o = 1'b1;
        wreg_o  = 1'b0;
        waddr_o = waddr_q;
        wdata_o = 32'd0;
        if (mem_ack_i && (k_q == last_k(op_q))) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        waddr_o = waddr_q;
        if (is_store(op_q)) begin
          wreg_o  = 1'b0;
          wdata_o = 32'd0;
        end else begin
          wreg_o = wreg_q;
          case (op_q)
            `ALU_LB_OP:  wdata_o = {{24{buf_q[7]}}, buf_q[7:0]};
            `ALU_LH_OP:  wdata_o = {{16{buf_q[15]}}, buf_q[15:0]};
            `ALU_LBU_OP: wdata_o = {24'd0, buf_q[7:0]};
            `ALU_LHU_OP: wdata_o = {16'd0, buf_q[15:0]};
            default:     wdata_o = buf_q;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
